// File: rtl/sort_pkg.sv
// Shared definitions for the sort RAM and the bubble-sort engine that drives it.
package sort_pkg;

  // Default geometry shared with the sort engine
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;

  // Request opcodes
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CSWAP = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4,
    ST_RESP = 3'd5
  } state_e;

endpackage

// File: rtl/sort_ram_core.sv
// Plain single-port synchronous RAM, registered read data (1-cycle latency).
// The array is called `ram` so benches can reach it hierarchically.
module sort_ram_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] r_dout;

  // Write-first is irrelevant here: read and write never target the same cycle's data
  always_ff @(posedge clk) begin
    if (i_we) begin
      ram[i_addr] <= i_din;
    end
    r_dout <= ram[i_addr];
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/sort_ram.sv
// Single-port RAM with request/response handshake and atomic compare-and-swap.
// The address of operand A is presented to the RAM while IDLE, so the read
// issued on the accept edge delivers mem[a] during RD_A; RD_A then issues the
// read of b, giving mem[b] during RD_B where the comparison is made.
module sort_ram
  import sort_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = 1024,
  parameter int SIGNED_CMP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_swapped,
  output logic              busy
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  // Swap decision: true when a must move behind b
  function automatic logic gt_cmp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED_CMP != 0) return $signed(a) > $signed(b);
    else                 return a > b;
  endfunction

  // Addresses beyond DEPTH read as zero and never get written
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < LP_DEPTH;
  endfunction

  state_e            r_state, w_state_nxt;
  op_e               r_op;
  logic [ADDR_W-1:0] r_addr_a, r_addr_b;
  logic [DATA_W-1:0] r_wdata, r_da, r_db;
  logic              r_rsp_valid, r_rsp_swapped;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din, w_dout, w_dout_m;
  logic [DATA_W-1:0] w_rsp_data_nxt;
  logic              w_rsp_swp_nxt, w_a_ok, w_b_ok;

  sort_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk    (clk),
    .i_we   (w_we),
    .i_addr (w_addr),
    .i_din  (w_din),
    .o_dout (w_dout)
  );

  assign w_a_ok   = in_range(r_addr_a);
  assign w_b_ok   = in_range(r_addr_b);
  // RAM output belongs to b during RD_B, otherwise to a
  assign w_dout_m = (r_state == ST_RD_B) ? (w_b_ok ? w_dout : '0)
                                         : (w_a_ok ? w_dout : '0);

  // Next state, RAM port control and the response that RESP will present
  always_comb begin
    w_state_nxt    = r_state;
    w_we           = 1'b0;
    w_addr         = r_addr_a;
    w_din          = r_wdata;
    w_rsp_data_nxt = '0;
    w_rsp_swp_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_addr = addr_a;
        if (req_valid) begin
          case (op_e'(req_op))
            OP_READ:  w_state_nxt = ST_RD_A;
            OP_WRITE: w_state_nxt = ST_WR_A;
            OP_CSWAP: w_state_nxt = ST_RD_A;
            default:  w_state_nxt = ST_RESP;
          endcase
        end
      end
      ST_RD_A: begin
        w_addr         = r_addr_b;
        w_rsp_data_nxt = w_dout_m;
        w_state_nxt    = (r_op == OP_READ) ? ST_RESP : ST_RD_B;
      end
      ST_RD_B: begin
        w_rsp_data_nxt = r_da;
        w_state_nxt    = gt_cmp(r_da, w_dout_m) ? ST_WR_A : ST_RESP;
      end
      ST_WR_A: begin
        w_we        = w_a_ok;
        w_din       = (r_op == OP_WRITE) ? r_wdata : r_db;
        w_state_nxt = (r_op == OP_WRITE) ? ST_RESP : ST_WR_B;
      end
      ST_WR_B: begin
        w_addr         = r_addr_b;
        w_we           = w_b_ok;
        w_din          = r_da;
        w_rsp_data_nxt = r_db;
        w_rsp_swp_nxt  = 1'b1;
        w_state_nxt    = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, captured request and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_READ;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_wdata  <= '0;
      r_da     <= '0;
      r_db     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && req_valid) begin
        r_op     <= op_e'(req_op);
        r_addr_a <= addr_a;
        r_addr_b <= addr_b;
        r_wdata  <= wdata;
      end
      if (r_state == ST_RD_A) r_da <= w_dout_m;
      if (r_state == ST_RD_B) r_db <= w_dout_m;
    end
  end

  // Response registers: loaded on entry to RESP, held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_swapped <= 1'b0;
    end else begin
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      if (w_state_nxt == ST_RESP) begin
        r_rsp_data    <= w_rsp_data_nxt;
        r_rsp_swapped <= w_rsp_swp_nxt;
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = ~req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_swapped = r_rsp_swapped;

endmodule

// File: tb/tb_sort_ram.sv
// Scoreboard bench for sort_ram: an unsigned full-depth instance and a
// signed instance with DEPTH=512 (for out-of-range addresses).
module tb_sort_ram;

  typedef struct {
    logic [15:0] data;
    logic        swp;
    int          lat;
    int          c0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_u = 1'b0, req_valid_s = 1'b0;
  logic [1:0]  req_op = 2'b11;
  logic [9:0]  addr_a = '0, addr_b = '0;
  logic [15:0] wdata = '0;

  logic        req_ready_u, rsp_valid_u, rsp_swapped_u, busy_u;
  logic [15:0] rsp_data_u;
  logic        req_ready_s, rsp_valid_s, rsp_swapped_s, busy_s;
  logic [15:0] rsp_data_s;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q_u[$];
  exp_t q_s[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sort_ram #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .SIGNED_CMP(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_u), .req_ready(req_ready_u),
    .req_op(req_op), .addr_a(addr_a), .addr_b(addr_b), .wdata(wdata),
    .rsp_valid(rsp_valid_u), .rsp_data(rsp_data_u), .rsp_swapped(rsp_swapped_u),
    .busy(busy_u)
  );

  sort_ram #(.DATA_W(16), .ADDR_W(10), .DEPTH(512), .SIGNED_CMP(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_s), .req_ready(req_ready_s),
    .req_op(req_op), .addr_a(addr_a), .addr_b(addr_b), .wdata(wdata),
    .rsp_valid(rsp_valid_s), .rsp_data(rsp_data_s), .rsp_swapped(rsp_swapped_s),
    .busy(busy_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_pop(input string tag, input exp_t e, input logic [15:0] d, input logic s);
    check({tag, " rsp_data"}, {16'h0, d}, {16'h0, e.data});
    check({tag, " rsp_swapped"}, {31'h0, s}, {31'h0, e.swp});
    check({tag, " latency"}, cyc - e.c0 + 1, e.lat);
  endtask

  // Monitors: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rsp_valid_u === 1'b1) begin
      if (q_u.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL u unexpected rsp: data %0h, expected no response", rsp_data_u);
      end else mon_pop("u", q_u.pop_front(), rsp_data_u, rsp_swapped_u);
    end
  end

  always @(negedge clk) begin
    if (rsp_valid_s === 1'b1) begin
      if (q_s.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL s unexpected rsp: data %0h, expected no response", rsp_data_s);
      end else mon_pop("s", q_s.pop_front(), rsp_data_s, rsp_swapped_s);
    end
  end

  function automatic int qsize(input bit sel);
    return sel ? q_s.size() : q_u.size();
  endfunction

  // Issue one request to the selected instance and wait for its response
  task automatic issue(input bit sel, input logic [1:0] op, input logic [9:0] a,
                       input logic [9:0] b, input logic [15:0] wd,
                       input logic [15:0] ed, input logic es, input int el);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!(sel ? req_ready_s : req_ready_u) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL ready timeout: got busy, expected req_ready within 20 cycles");
      return;
    end
    req_op = op; addr_a = a; addr_b = b; wdata = wd;
    if (sel) req_valid_s = 1'b1; else req_valid_u = 1'b1;
    @(posedge clk);
    #1;
    req_valid_u = 1'b0; req_valid_s = 1'b0;
    e.data = ed; e.swp = es; e.lat = el; e.c0 = cyc;
    if (sel) q_s.push_back(e); else q_u.push_back(e);
    n = 0;
    while (qsize(sel) != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (qsize(sel) != 0) begin
      n_checks++; n_fail++;
      $display("FAIL rsp timeout: got no rsp_valid, expected one within 20 cycles");
      if (sel) q_s.delete(); else q_u.delete();
    end
  endtask

  initial begin
    int   n;
    exp_t e;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst rsp_valid_u", rsp_valid_u, 0);
    check("rst rsp_data_u", rsp_data_u, 0);
    check("rst rsp_swapped_u", rsp_swapped_u, 0);
    check("rst req_ready_u", req_ready_u, 1);
    check("rst busy_s", busy_s, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload through WRITE requests (ack at +2, data 0)
    issue(0, 2'b01, 10'd0, 10'd0, 16'h0005, 16'h0000, 0, 2);
    issue(0, 2'b01, 10'd1, 10'd0, 16'h0003, 16'h0000, 0, 2);
    issue(0, 2'b01, 10'd2, 10'd0, 16'hFFFF, 16'h0000, 0, 2);
    issue(0, 2'b01, 10'd3, 10'd0, 16'h0001, 16'h0000, 0, 2);
    issue(0, 2'b01, 10'd4, 10'd0, 16'h1234, 16'h0000, 0, 2);
    issue(0, 2'b01, 10'd5, 10'd0, 16'h0009, 16'h0000, 0, 2);
    issue(0, 2'b01, 10'd6, 10'd0, 16'h0002, 16'h0000, 0, 2);
    issue(1, 2'b01, 10'd2, 10'd0, 16'hFFFF, 16'h0000, 0, 2);
    issue(1, 2'b01, 10'd3, 10'd0, 16'h0001, 16'h0000, 0, 2);

    // READ, WRITE/READ-back
    issue(0, 2'b00, 10'd0, 10'd0, 16'h0000, 16'h0005, 0, 2);
    issue(0, 2'b01, 10'd7, 10'd0, 16'hBEEF, 16'h0000, 0, 2);
    issue(0, 2'b00, 10'd7, 10'd0, 16'h0000, 16'hBEEF, 0, 2);

    // CSWAP with swap: 5 > 3
    issue(0, 2'b10, 10'd0, 10'd1, 16'h0000, 16'h0003, 1, 5);
    check("cswap mem[0]", dut_u.u_core.ram[0], 16'h0003);
    check("cswap mem[1]", dut_u.u_core.ram[1], 16'h0005);

    // Signed compare: -1 > 1 is false
    issue(1, 2'b10, 10'd2, 10'd3, 16'h0000, 16'hFFFF, 0, 3);
    check("signed mem[2]", dut_s.u_core.ram[2], 16'hFFFF);
    check("signed mem[3]", dut_s.u_core.ram[3], 16'h0001);

    // Unsigned compare: 0xFFFF > 1
    issue(0, 2'b10, 10'd2, 10'd3, 16'h0000, 16'h0001, 1, 5);
    check("unsigned mem[2]", dut_u.u_core.ram[2], 16'h0001);
    check("unsigned mem[3]", dut_u.u_core.ram[3], 16'hFFFF);

    // Same address never swaps
    issue(0, 2'b10, 10'd4, 10'd4, 16'h0000, 16'h1234, 0, 3);
    check("a==b mem[4]", dut_u.u_core.ram[4], 16'h1234);
    repeat (3) @(negedge clk);
    check("hold rsp_data", rsp_data_u, 16'h1234);
    check("hold rsp_valid", rsp_valid_u, 0);

    // req_valid held through busy: CSWAP (3 vs 5, no swap) then NOP
    @(negedge clk);
    req_op = 2'b10; addr_a = 10'd0; addr_b = 10'd1; wdata = 16'h0;
    req_valid_u = 1'b1;
    @(posedge clk);
    #1;
    e.data = 16'h0003; e.swp = 0; e.lat = 3; e.c0 = cyc;
    q_u.push_back(e);
    req_op = 2'b11; addr_a = 10'd9; addr_b = 10'd9;
    n = 0;
    @(negedge clk);
    while (!req_ready_u && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy cycles", n, 3);
    @(posedge clk);
    #1;
    e.data = 16'h0000; e.swp = 0; e.lat = 1; e.c0 = cyc;
    q_u.push_back(e);
    req_valid_u = 1'b0;
    repeat (4) @(posedge clk);
    check("nop drained", q_u.size(), 0);
    check("held mem[0]", dut_u.u_core.ram[0], 16'h0003);

    // Out-of-range operand on DEPTH=512 instance: 1 > 0 swaps, write to 600 dropped
    issue(1, 2'b10, 10'd3, 10'd600, 16'h0000, 16'h0000, 1, 5);
    check("oor mem[3]", dut_s.u_core.ram[3], 16'h0000);
    issue(1, 2'b01, 10'd600, 10'd0, 16'hAAAA, 16'h0000, 0, 2);
    issue(1, 2'b00, 10'd600, 10'd0, 16'h0000, 16'h0000, 0, 2);

    // Reset during WR_B of a swap (9 > 2)
    issue(0, 2'b10, 10'd0, 10'd1, 16'h0000, 16'h0003, 0, 3);
    @(negedge clk);
    req_op = 2'b10; addr_a = 10'd5; addr_b = 10'd6;
    req_valid_u = 1'b1;
    @(posedge clk);
    #1;
    req_valid_u = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("wr_b busy", busy_u, 1);
    check("wr_b rsp_data", rsp_data_u, 16'h0003);
    rst_n = 1'b0;
    #1;
    check("abort rsp_valid", rsp_valid_u, 0);
    check("abort rsp_data", rsp_data_u, 0);
    check("abort rsp_swapped", rsp_swapped_u, 0);
    check("abort req_ready", req_ready_u, 1);
    repeat (2) @(posedge clk);
    #1;
    check("abort mem[a]", dut_u.u_core.ram[5], 16'h0002);
    check("abort mem[b]", dut_u.u_core.ram[6], 16'h0002);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 2'b00, 10'd6, 10'd0, 16'h0000, 16'h0002, 0, 2);
    issue(0, 2'b00, 10'd5, 10'd0, 16'h0000, 16'h0002, 0, 2);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_ram.md
Name: sort_ram

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 16x1024 data RAM; adds a request/response handshake and an atomic compare-and-swap (CSWAP) operation.
- The bubble-sort engine issues one CSWAP per adjacent pair and never sequences reads and writes itself.
- Storage array is named `ram` so benches can preload it with `$readmemh` and dump it with `$writememh` hierarchically.

Parameters:
- DATA_W, 16: word width in bits.
- ADDR_W, 10: address width in bits.
- DEPTH, 1024: number of words. Must satisfy DEPTH <= 2**ADDR_W.
- SIGNED_CMP, 0: 0 = unsigned compare for CSWAP; 1 = two's-complement compare.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_op  in  2  operation: 00 READ, 01 WRITE, 10 CSWAP, 11 NOP.
- addr_a  in  ADDR_W  primary address (READ, WRITE, CSWAP).
- addr_b  in  ADDR_W  second address (CSWAP only).
- wdata  in  DATA_W  write data (WRITE only).
- rsp_valid  out  1  single-cycle completion pulse.
- rsp_data  out  DATA_W  READ: mem[a]. CSWAP: final mem[a]. WRITE/NOP: 0.
- rsp_swapped  out  1  CSWAP performed a swap.
- busy  out  1  equals ~req_ready.

Behaviour:
- Reset (async assert, sync deassert by design): state = IDLE, rsp_valid = 0, rsp_data = 0, rsp_swapped = 0, all captured registers = 0. Memory contents are not cleared.
- Accept: on a clk edge with req_valid & req_ready, capture op, addr_a, addr_b and wdata. Inputs are ignored outside IDLE. There is no response backpressure.
- FSM states: IDLE, RD_A, RD_B, WR_A, WR_B, RESP. One memory access per cycle; synchronous read with 1-cycle latency.
- READ: IDLE -> RD_A -> RESP. rsp_valid is high in the 2nd cycle after the accept edge.
- WRITE: IDLE -> WR_A -> RESP. mem[a] is written at the edge ending WR_A; rsp_valid is high in the 2nd cycle after accept.
- NOP: IDLE -> RESP. rsp_valid is high in the 1st cycle after accept; rsp_data = 0.
- CSWAP: IDLE -> RD_A -> RD_B, which captures da and db.
  - If da > db (per SIGNED_CMP): -> WR_A (mem[a] <= db) -> WR_B (mem[b] <= da) -> RESP. rsp_swapped = 1, rsp_data = db. rsp_valid in the 5th cycle after accept.
  - Else: -> RESP. rsp_swapped = 0, rsp_data = da. rsp_valid in the 3rd cycle after accept.
- RESP -> IDLE unconditionally. rsp_data and rsp_swapped hold their values until the next RESP.
- Boundary conditions:
  - addr_a == addr_b on CSWAP: never swaps (da == db).
  - Address >= DEPTH: write suppressed, read returns 0. A CSWAP with an out-of-range operand compares against 0 and suppresses the write to that address.
  - Equal values never swap, so the sort is stable.
  - Reset mid-CSWAP: aborts immediately. Reset between WR_A and WR_B leaves only mem[a] updated; this is documented and accepted, and the sort engine restarts its pass after reset.
  - Back-to-back requests: minimum spacing = latency + 1 cycles (RESP -> IDLE, then accept).

Decomposition:
- Shared package (sort_pkg):
  - op encodings OP_READ, OP_WRITE, OP_CSWAP, OP_NOP;
  - state encoding constants;
  - default DATA_W and ADDR_W shared with the sort engine.
- One sub-module, sort_ram_core: plain parametrised single-port synchronous RAM holding array `ram`, with we, addr, din and registered dout.
- sort_ram wraps the core with the FSM and comparator.

Test Plan:
- Preload `ram` via `$readmemh` (mem[0]=0x0005, mem[1]=0x0003); READ addr 0 -> rsp_valid 2 cycles after accept, rsp_data=0x0005.
- WRITE addr 7, wdata 0xBEEF, then READ addr 7 -> WRITE ack at +2 with rsp_data=0; READ returns 0xBEEF.
- CSWAP a=0, b=1 on 0x0005/0x0003 -> rsp_valid at +5, rsp_swapped=1, rsp_data=0x0003; `$writememh` dump shows mem[0]=0x0003, mem[1]=0x0005.
- SIGNED_CMP=1, mem[2]=0xFFFF, mem[3]=0x0001, CSWAP a=2, b=3 -> no swap at +3, rsp_data=0xFFFF. Same values with SIGNED_CMP=0 -> swap.
- CSWAP a=b=4; req_valid held during busy; op=11 -> no swap. Second request is not accepted until req_ready; NOP acks at +1.
- Assert rst_n low in WR_B of a swap -> outputs go to 0 asynchronously, state IDLE, mem[a] already updated, mem[b] unchanged.
